// File: rtl/decode_stage_reg_if.sv
// Handshake and decoded-field bundle between instruction fetch and the
// stage-1 decode register; master drives the request side, slave is the stage.
interface decode_stage_reg_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned REG_AW = 5
);
  logic              flush;
  logic [DATA_W-1:0] instr_in;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   alu_op;
  logic [REG_AW-1:0] ws;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [DATA_W-1:0] imm;
  logic              ds;
  logic              we;
  logic [1:0]        occupancy;

  modport master (
    output flush, instr_in, in_valid, out_ready,
    input  in_ready, out_valid, alu_op, ws, rs1, rs2, imm, ds, we, occupancy
  );

  modport slave (
    input  flush, instr_in, in_valid, out_ready,
    output in_ready, out_valid, alu_op, ws, rs1, rs2, imm, ds, we, occupancy
  );
endinterface

// File: rtl/decode_stage_reg.sv
// Stage-1 decode register: splits instruction words into fields and holds them
// in a 2-entry skid buffer so in_ready is a flop, not a path from out_ready.
module decode_stage_reg #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned OP_W        = 6,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned IMM_W       = 16,
  parameter int unsigned IMM_SEL_BIT = 29,
  parameter bit          SIGN_EXT    = 1'b0,
  parameter bit          R0_WE_OFF   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  decode_stage_reg_if.slave  bus
);

  localparam int unsigned WS_HI  = DATA_W - OP_W - 1;
  localparam int unsigned RS1_HI = WS_HI - REG_AW;
  localparam int unsigned RS2_HI = RS1_HI - REG_AW;

  typedef struct packed {
    logic [OP_W-1:0]   alu_op;
    logic [REG_AW-1:0] ws;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [DATA_W-1:0] imm;
    logic              ds;
    logic              we;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t     state_q, state_d;
  entry_t     main_q, skid_q, dec;
  logic       in_ready_q, out_valid_q;
  logic [1:0] occ_q;
  logic       in_fire, out_fire;

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  always_comb begin
    dec        = '0;
    dec.alu_op = bus.instr_in[DATA_W-1 -: OP_W];
    dec.ws     = bus.instr_in[WS_HI -: REG_AW];
    dec.rs1    = bus.instr_in[RS1_HI -: REG_AW];
    dec.ds     = bus.instr_in[IMM_SEL_BIT];
    if (dec.ds) begin
      dec.imm = SIGN_EXT ? {{(DATA_W-IMM_W){bus.instr_in[IMM_W-1]}}, bus.instr_in[IMM_W-1:0]}
                         : {{(DATA_W-IMM_W){1'b0}}, bus.instr_in[IMM_W-1:0]};
    end else begin
      dec.rs2 = bus.instr_in[RS2_HI -: REG_AW];
    end
    dec.we = !(R0_WE_OFF && (dec.ws == '0));
  end

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (in_fire) state_d = ONE;
        ONE: begin
          if (in_fire && !out_fire)      state_d = FULL;
          else if (!in_fire && out_fire) state_d = EMPTY;
        end
        FULL:    if (out_fire) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with the entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= (state_d == FULL) ? 2'd2 : (state_d == ONE) ? 2'd1 : 2'd0;
      if (!bus.flush) begin
        case (state_q)
          EMPTY: if (in_fire) main_q <= dec;
          ONE: begin
            if (in_fire) begin
              if (out_fire) main_q <= dec;
              else          skid_q <= dec;
            end
          end
          FULL:    if (out_fire) main_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.occupancy = occ_q;
  assign bus.alu_op    = main_q.alu_op;
  assign bus.ws        = main_q.ws;
  assign bus.rs1       = main_q.rs1;
  assign bus.rs2       = main_q.rs2;
  assign bus.imm       = main_q.imm;
  assign bus.ds        = main_q.ds;
  assign bus.we        = main_q.we;

endmodule

// File: tb/tb_decode_stage_reg.sv
// Scoreboard bench: two decode stages (sign-extend + r0 suppression, and
// zero-extend without suppression) share stimulus; expected entries are queued.
module tb_decode_stage_reg;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  ws;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        ds;
    logic        we;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        in_valid, flush, out_ready;
  int          cur;
  int          total = 0;
  int          bad   = 0;

  logic [31:0] vin  [6];
  dec_t        exp_a[6];
  dec_t        exp_b[6];
  dec_t        qa[$];
  dec_t        qb[$];

  always #5 clk = ~clk;

  decode_stage_reg_if #(.DATA_W(32), .OP_W(6), .REG_AW(5)) ifa ();
  decode_stage_reg_if #(.DATA_W(32), .OP_W(6), .REG_AW(5)) ifb ();

  assign ifa.instr_in = instr;    assign ifb.instr_in = instr;
  assign ifa.in_valid = in_valid; assign ifb.in_valid = in_valid;
  assign ifa.flush = flush;       assign ifb.flush = flush;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready;

  decode_stage_reg #(.DATA_W(32), .OP_W(6), .REG_AW(5), .IMM_W(16), .IMM_SEL_BIT(29),
                     .SIGN_EXT(1'b1), .R0_WE_OFF(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  decode_stage_reg #(.DATA_W(32), .OP_W(6), .REG_AW(5), .IMM_W(16), .IMM_SEL_BIT(29),
                     .SIGN_EXT(1'b0), .R0_WE_OFF(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  function automatic dec_t mk(input logic [5:0] op, input logic [4:0] ws, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic ds,
                              input logic we);
    dec_t d;
    d.op = op; d.ws = ws; d.rs1 = rs1; d.rs2 = rs2; d.imm = imm; d.ds = ds; d.we = we;
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Reference flow: accept while fewer than two held, deliver oldest first, flush empties.
  always @(posedge clk) begin
    if (rst) begin
      qa.delete(); qb.delete();
    end else if (flush) begin
      qa.delete(); qb.delete();
    end else if (in_valid && qa.size() != 2) begin
      if (out_ready && qa.size() != 0) begin
        void'(qa.pop_front()); void'(qb.pop_front());
      end
      qa.push_back(exp_a[cur]); qb.push_back(exp_b[cur]);
    end else if (out_ready && qa.size() != 0) begin
      void'(qa.pop_front()); void'(qb.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("a_out_valid", 64'(ifa.out_valid), 64'(qa.size() != 0));
    chk("a_in_ready",  64'(ifa.in_ready),  64'(qa.size() != 2));
    chk("a_occupancy", 64'(ifa.occupancy), 64'(qa.size()));
    chk("b_out_valid", 64'(ifb.out_valid), 64'(qb.size() != 0));
    chk("b_in_ready",  64'(ifb.in_ready),  64'(qb.size() != 2));
    chk("b_occupancy", 64'(ifb.occupancy), 64'(qb.size()));
    if (ifa.out_valid && qa.size() != 0)
      chk("a_payload", 64'({ifa.alu_op, ifa.ws, ifa.rs1, ifa.rs2, ifa.imm, ifa.ds, ifa.we}), 64'(qa[0]));
    if (ifb.out_valid && qb.size() != 0)
      chk("b_payload", 64'({ifb.alu_op, ifb.ws, ifb.rs1, ifb.rs2, ifb.imm, ifb.ds, ifb.we}), 64'(qb[0]));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int idx);
    cur = idx; instr = vin[idx]; in_valid = 1'b1;
    step();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_payload"}, 64'({ifa.alu_op, ifa.ws, ifa.rs1, ifa.rs2, ifa.imm, ifa.ds, ifa.we}), 64'd0);
    chk({tag, "_b_payload"}, 64'({ifb.alu_op, ifb.ws, ifb.rs1, ifb.rs2, ifb.imm, ifb.ds, ifb.we}), 64'd0);
    chk({tag, "_a_in_ready"}, 64'(ifa.in_ready), 64'd1);
    chk({tag, "_a_out_valid"}, 64'(ifa.out_valid), 64'd0);
    chk({tag, "_a_occupancy"}, 64'(ifa.occupancy), 64'd0);
  endtask

  initial begin
    // R-form, I-form negative imm, ws=0 R-form, ws=0 I-form positive imm, all-ones R, all-ones I
    vin[0] = 32'h0C43_1800; exp_a[0] = mk(6'h03, 5'd2, 5'd3, 5'd3, 32'h0, 1'b0, 1'b1);
                            exp_b[0] = mk(6'h03, 5'd2, 5'd3, 5'd3, 32'h0, 1'b0, 1'b1);
    vin[1] = 32'h2422_8000; exp_a[1] = mk(6'h09, 5'd1, 5'd2, 5'd0, 32'hFFFF_8000, 1'b1, 1'b1);
                            exp_b[1] = mk(6'h09, 5'd1, 5'd2, 5'd0, 32'h0000_8000, 1'b1, 1'b1);
    vin[2] = 32'h0C03_1800; exp_a[2] = mk(6'h03, 5'd0, 5'd3, 5'd3, 32'h0, 1'b0, 1'b0);
                            exp_b[2] = mk(6'h03, 5'd0, 5'd3, 5'd3, 32'h0, 1'b0, 1'b1);
    vin[3] = 32'h2000_7FFF; exp_a[3] = mk(6'h08, 5'd0, 5'd0, 5'd0, 32'h0000_7FFF, 1'b1, 1'b0);
                            exp_b[3] = mk(6'h08, 5'd0, 5'd0, 5'd0, 32'h0000_7FFF, 1'b1, 1'b1);
    vin[4] = 32'hDFFF_FFFF; exp_a[4] = mk(6'h37, 5'd31, 5'd31, 5'd31, 32'h0, 1'b0, 1'b1);
                            exp_b[4] = mk(6'h37, 5'd31, 5'd31, 5'd31, 32'h0, 1'b0, 1'b1);
    vin[5] = 32'hFFFF_FFFF; exp_a[5] = mk(6'h3F, 5'd31, 5'd31, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b1);
                            exp_b[5] = mk(6'h3F, 5'd31, 5'd31, 5'd0, 32'h0000_FFFF, 1'b1, 1'b1);

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; instr = '0; cur = 0;
    #2;
    chk_reset_outputs("reset");
    step(); step();
    rst = 1'b0;

    // streaming decode of every vector
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(i);
    in_valid = 1'b0;
    repeat (3) step();

    // backpressure: two held, third waits until a slot frees
    out_ready = 1'b0;
    send(1); send(4);
    cur = 5; instr = vin[5]; in_valid = 1'b1;
    repeat (3) step();
    out_ready = 1'b1;
    step(); step();
    in_valid = 1'b0;
    repeat (3) step();

    // flush while full with a word offered
    out_ready = 1'b0;
    send(0); send(2);
    cur = 3; instr = vin[3]; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    send(4);
    in_valid = 1'b0;
    repeat (2) step();

    // flush in ONE with a simultaneous delivery
    send(1);
    cur = 5; instr = vin[5]; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    repeat (2) step();

    // async reset between edges while full
    out_ready = 1'b0;
    send(0); send(1);
    in_valid = 1'b0;
    step();
    rst = 1'b1; qa.delete(); qb.delete();
    #2;
    chk_reset_outputs("async_rst");
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    send(2);
    in_valid = 1'b0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
